// File: rtl/divider_16.sv
// Sequential signed Q2.13 divider: restoring radix-2, one quotient bit per clock,
// fixed 17-cycle issue interval, saturating on overflow and divide-by-zero.
module divider_16 #(
    parameter int DATA_W = 16,
    parameter int FRAC_W = 13
) (
    input  logic              I_CLK,
    input  logic              I_RST,
    input  logic              I_VLD,
    input  logic [DATA_W-1:0] I_DIVIDEND,
    input  logic [DATA_W-1:0] I_DIVISOR,
    output logic              O_VLD,
    output logic              O_DIV_BUSY,
    output logic [DATA_W-1:0] O_QUOTIENT,
    output logic              O_OVF,
    output logic              O_DIV_ZERO
);
    localparam int MAG_W = DATA_W - 1;
    localparam int INT_W = MAG_W - FRAC_W;
    localparam logic [3:0] LAST = 4'(MAG_W - 1);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    state_t state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [MAG_W-1:0]  b_mag_q, b_mag_d;
    logic [MAG_W-1:0]  rem_q, rem_d;
    logic [MAG_W-1:0]  num_q, num_d;
    logic [MAG_W-1:0]  quo_q, quo_d;
    logic              sign_q, sign_d, zero_q, zero_d, ovf_q, ovf_d;
    logic              a_zero_q, a_zero_d, a_neg_q, a_neg_d;
    logic              vld_q, vld_d, busy_q, busy_d;
    logic [DATA_W-1:0] quot_q, quot_d;
    logic              ovf_o_q, ovf_o_d, dz_q, dz_d;

    logic [MAG_W-1:0]  a_mag_in, b_mag_in;
    logic [MAG_W:0]    trial, diff;
    logic              fit;

    // 0x8000 has no positive counterpart and maps to magnitude 0.
    function automatic logic [MAG_W-1:0] mag(input logic [DATA_W-1:0] v);
        logic [DATA_W-1:0] n;
        n = -v;
        return v[DATA_W-1] ? n[MAG_W-1:0] : v[MAG_W-1:0];
    endfunction

    function automatic logic [DATA_W+1:0] select_result(
        input logic sign, input logic zero, input logic ovf,
        input logic a_neg, input logic a_zero, input logic [MAG_W-1:0] q);
        logic [DATA_W-1:0] pos_sat, neg_sat, neg_q;
        pos_sat = {1'b0, {MAG_W{1'b1}}};
        neg_sat = {1'b1, {(MAG_W-1){1'b0}}, 1'b1};
        neg_q   = -{1'b0, q};
        if (zero)
            return {(a_neg && !a_zero) ? neg_sat : pos_sat, 1'b0, 1'b1};
        else if (ovf)
            return {sign ? neg_sat : pos_sat, 1'b1, 1'b0};
        else if (q == '0)
            return {{DATA_W{1'b0}}, 1'b0, 1'b0};
        else
            return {sign ? neg_q : {1'b0, q}, 1'b0, 1'b0};
    endfunction

    always_comb begin
        a_mag_in = mag(I_DIVIDEND);
        b_mag_in = mag(I_DIVISOR);
        trial    = {rem_q, num_q[MAG_W-1]};
        diff     = trial - {1'b0, b_mag_q};
        fit      = (trial >= {1'b0, b_mag_q});

        state_d  = state_q;
        cnt_d    = cnt_q;
        b_mag_d  = b_mag_q;
        rem_d    = rem_q;
        num_d    = num_q;
        quo_d    = quo_q;
        sign_d   = sign_q;
        zero_d   = zero_q;
        ovf_d    = ovf_q;
        a_zero_d = a_zero_q;
        a_neg_d  = a_neg_q;
        vld_d    = 1'b0;
        busy_d   = busy_q;
        quot_d   = quot_q;
        ovf_o_d  = ovf_o_q;
        dz_d     = dz_q;

        case (state_q)
            S_IDLE: begin
                if (I_VLD) begin
                    // Numerator is |a|<<FRAC_W; its top bits seed the remainder, the rest shift in.
                    rem_d    = a_mag_in >> INT_W;
                    num_d    = {a_mag_in[INT_W-1:0], {FRAC_W{1'b0}}};
                    b_mag_d  = b_mag_in;
                    quo_d    = '0;
                    sign_d   = I_DIVIDEND[DATA_W-1] ^ I_DIVISOR[DATA_W-1];
                    zero_d   = (b_mag_in == '0);
                    ovf_d    = ({{INT_W{1'b0}}, a_mag_in} >= {b_mag_in, {INT_W{1'b0}}});
                    a_zero_d = (a_mag_in == '0);
                    a_neg_d  = I_DIVIDEND[DATA_W-1];
                    cnt_d    = '0;
                    busy_d   = 1'b1;
                    state_d  = S_CALC;
                end
            end
            S_CALC: begin
                rem_d = fit ? diff[MAG_W-1:0] : trial[MAG_W-1:0];
                quo_d = {quo_q[MAG_W-2:0], fit};
                num_d = num_q << 1;
                if (cnt_q == LAST)
                    state_d = S_DONE;
                else
                    cnt_d = cnt_q + 4'd1;
            end
            S_DONE: begin
                {quot_d, ovf_o_d, dz_d} = select_result(sign_q, zero_q, ovf_q,
                                                        a_neg_q, a_zero_q, quo_q);
                vld_d   = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge I_CLK) begin
        if (I_RST) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            b_mag_q  <= '0;
            rem_q    <= '0;
            num_q    <= '0;
            quo_q    <= '0;
            sign_q   <= 1'b0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
            a_zero_q <= 1'b0;
            a_neg_q  <= 1'b0;
            vld_q    <= 1'b0;
            busy_q   <= 1'b0;
            quot_q   <= '0;
            ovf_o_q  <= 1'b0;
            dz_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            b_mag_q  <= b_mag_d;
            rem_q    <= rem_d;
            num_q    <= num_d;
            quo_q    <= quo_d;
            sign_q   <= sign_d;
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
            a_zero_q <= a_zero_d;
            a_neg_q  <= a_neg_d;
            vld_q    <= vld_d;
            busy_q   <= busy_d;
            quot_q   <= quot_d;
            ovf_o_q  <= ovf_o_d;
            dz_q     <= dz_d;
        end
    end

    assign O_VLD      = vld_q;
    assign O_DIV_BUSY = busy_q;
    assign O_QUOTIENT = quot_q;
    assign O_OVF      = ovf_o_q;
    assign O_DIV_ZERO = dz_q;
endmodule

// File: doc/divider_16.md
Name: divider_16

Overview:
- Sequential 16-bit signed fixed-point divider (Q2.13, two's complement): the inverse operation of the 16-bit pipelined multiplier in the MHA datapath.
- Used by softmax normalisation and scaling stages where a value must be divided by a running sum or scale factor.
- Computes one quotient bit per clock (restoring radix-2) with the same valid/busy handshake as the multiplier.
- Saturates on overflow and on divide-by-zero.

Parameters:
- DATA_W, 16: operand and result width (sign + magnitude bits). Only the default is verified.
- FRAC_W, 13: number of fractional bits in operands and result.

Ports:
- I_CLK  in  1  clock, rising edge.
- I_RST  in  1  synchronous active-high reset.
- I_VLD  in  1  operand valid; accepted only when O_DIV_BUSY=0.
- I_DIVIDEND  in  16  dividend, Q2.13 two's complement.
- I_DIVISOR  in  16  divisor, Q2.13 two's complement.
- O_VLD  out  1  single-cycle pulse: O_QUOTIENT and flags are valid.
- O_DIV_BUSY  out  1  operation in progress; new I_VLD is ignored.
- O_QUOTIENT  out  16  quotient, Q2.13 two's complement. Held until the next O_VLD.
- O_OVF  out  1  result saturated because |quotient| >= 4.0. Qualified by O_VLD.
- O_DIV_ZERO  out  1  divisor was zero. Qualified by O_VLD.

Behaviour:
- One clock, synchronous active-high reset.
- Reset (at any time, including mid-operation): O_VLD=0, O_DIV_BUSY=0, O_QUOTIENT=0, O_OVF=0, O_DIV_ZERO=0. The iteration counter and internal registers clear. Any in-flight operation is discarded and produces no O_VLD.
- States: IDLE, CALC, DONE.
- IDLE, on edge E0 with I_VLD=1:
  - Register magnitudes |a| and |b| (15 bits each). 0x8000 is treated as magnitude 0, matching the multiplier.
  - Register sign = a[15]^b[15].
  - Register zero flag (|b|==0), overflow flag ({2'b0,|a|} >= {|b|,2'b00}), and dividend-zero flag (|a|==0).
  - Set O_DIV_BUSY=1, counter=0, go to CALC.
- CALC:
  - Edges E1..E15 each produce one quotient bit, MSB first, of floor(|a|*2^13 / |b|). Counter runs 0..14.
  - When the zero or overflow flag is set, the iterations still run (fixed latency) but their result is discarded.
- DONE, on edge E16:
  - O_VLD<=1 for exactly one cycle.
  - O_DIV_BUSY<=0 at the same edge.
  - Return to IDLE.
  - Fixed latency: O_VLD is high in the cycle after E16. Maximum throughput is one operation per 17 cycles; the next accept can occur at E17.
- Result selection, in priority order:
  - Divisor zero: O_DIV_ZERO=1, O_OVF=0. O_QUOTIENT=0x7FFF if the dividend sign is 0 (including dividend 0), otherwise 0x8001.
  - Overflow: O_OVF=1. O_QUOTIENT=0x7FFF if sign=0, otherwise 0x8001. 0x8000 is never produced.
  - Otherwise: magnitude q (15 bits, truncated toward zero). O_QUOTIENT = sign ? -{1'b0,q} : {1'b0,q}. If q==0, O_QUOTIENT=0x0000 (no negative zero).
- I_VLD while O_DIV_BUSY=1, including the DONE cycle: ignored. No queuing, operands are not re-sampled.
- I_VLD is sampled only in IDLE. The operands need not be held after the accept edge.
- O_QUOTIENT, O_OVF and O_DIV_ZERO update only at the DONE edge and hold their values otherwise.

Test Plan:
- Reset, then 0x2000 / 0x4000 (1.0/2.0) -> O_VLD pulse exactly 17 cycles after accept, O_QUOTIENT=0x1000, O_OVF=0, O_DIV_ZERO=0, O_DIV_BUSY high for 16 cycles.
- 0xE000 / 0x1000 (-1.0/0.5) -> 0xC000. Then 0x2000 / 0x6000 (1/3) -> 0x0AAA (truncation). Then 0x6000 / 0x3000 -> 0x4000.
- 0x7FFF / 0x0800 -> O_QUOTIENT=0x7FFF, O_OVF=1. 0x9000 / 0x0800 -> 0x8001, O_OVF=1.
- 0xE000 / 0x0000 -> 0x8001, O_DIV_ZERO=1. 0x0000 / 0x0000 -> 0x7FFF, O_DIV_ZERO=1. 0x0000 / 0xC000 -> 0x0000, flags 0.
- Assert I_VLD continuously with changing operands -> only the operands present in IDLE cycles are accepted; back-to-back results are 17 cycles apart; no O_VLD occurs while busy except at the scheduled edge.
- Assert I_RST at counter=7 -> all outputs 0 on the next edge, no O_VLD. A new request afterwards completes correctly with full latency.
